// File: rtl/tpsram_fifo_ctrl.sv
// tpsram_fifo_ctrl: FIFO controller over a two-port SRAM (write port A, read port B)
// with a 2-entry show-ahead buffer hiding the 1-cycle read latency.
module tpsram_fifo_ctrl #(
    parameter int MEM_DEPTH  = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 75
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  WrValid,
    output logic                  WrReady,
    input  logic [DATA_WIDTH-1:0] WrData,
    output logic                  RdValid,
    input  logic                  RdReady,
    output logic [DATA_WIDTH-1:0] RdData,
    output logic [ADDR_WIDTH:0]   Count,
    output logic                  OvfErr,
    output logic                  CEAB,
    output logic                  WEAB,
    output logic [ADDR_WIDTH-1:0] AddrA,
    output logic [DATA_WIDTH-1:0] Din,
    output logic                  CEBB,
    output logic                  REBB,
    output logic [ADDR_WIDTH-1:0] AddrB,
    input  logic [DATA_WIDTH-1:0] Q
);
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(MEM_DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0] obuf [2];
    logic [1:0]            occ, pend;
    logic                  hd, inflight, wr_acc, pop, issue;

    assign WrReady = !Rst && Count < FULL;
    assign wr_acc  = WrValid && WrReady;
    assign RdValid = occ != 2'd0;
    assign RdData  = obuf[hd];
    assign pop     = RdValid && RdReady;
    // Slots still claimed next cycle once this cycle's pop is accounted for
    assign pend    = occ + 2'(inflight) - 2'(pop);
    assign issue   = !Rst && Count != '0 && pend < 2'd2;
    assign CEAB    = !wr_acc;
    assign WEAB    = !wr_acc;
    assign AddrA   = wr_ptr;
    assign Din     = WrData;
    assign CEBB    = !issue;
    assign REBB    = !issue;
    assign AddrB   = rd_ptr;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            Count    <= '0;
            occ      <= 2'd0;
            hd       <= 1'b0;
            inflight <= 1'b0;
            OvfErr   <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (issue) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            Count    <= Count + (ADDR_WIDTH+1)'(wr_acc) - (ADDR_WIDTH+1)'(issue);
            inflight <= issue;
            // Tail slot is head+occ; when full and popping, the freed head slot is reused
            if (inflight) obuf[hd ^ occ[0]] <= Q;
            if (pop) hd <= !hd;
            occ <= occ + 2'(inflight) - 2'(pop);
            if (inflight && occ == 2'd2 && !pop) OvfErr <= 1'b1;
        end
    end
endmodule

// File: tb/tb_tpsram_fifo_ctrl.sv
// tb_tpsram_fifo_ctrl: directed bench for tpsram_fifo_ctrl with a behavioural SRAM model.
module tb_tpsram_fifo_ctrl;
    localparam int DEPTH = 1024, AW = 10, DW = 75;

    logic          Clk = 1'b0, Rst, WrValid, RdReady;
    logic [DW-1:0] WrData, RdData, Din, Q;
    logic          WrReady, RdValid, OvfErr, CEAB, WEAB, CEBB, REBB;
    logic [AW:0]   Count;
    logic [AW-1:0] AddrA, AddrB;
    logic [DW-1:0] mem [DEPTH];
    int            n_tests = 0, n_fail = 0;

    tpsram_fifo_ctrl #(.MEM_DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .Clk(Clk), .Rst(Rst), .WrValid(WrValid), .WrReady(WrReady), .WrData(WrData),
        .RdValid(RdValid), .RdReady(RdReady), .RdData(RdData), .Count(Count), .OvfErr(OvfErr),
        .CEAB(CEAB), .WEAB(WEAB), .AddrA(AddrA), .Din(Din),
        .CEBB(CEBB), .REBB(REBB), .AddrB(AddrB), .Q(Q)
    );

    always #5 Clk = ~Clk;

    // Two-port SRAM: synchronous write on A, registered read on B
    always @(posedge Clk) begin
        if (!CEAB && !WEAB) mem[AddrA] <= Din;
        if (!CEBB && !REBB) Q <= mem[AddrB];
    end

    task automatic step();
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        Rst = 1; WrValid = 0; RdReady = 0; WrData = '0;
        step(); step();
        Rst = 0;
        for (int i = 0; i < 5; i++) begin WrValid = 1; WrData = DW'(100 + i); step(); end
        WrValid = 0;
        repeat (4) step();
        n_tests++; if (RdValid !== 1'b1) begin n_fail++; $display("FAIL rst_pre_rdvalid: got %b expected 1", RdValid); end
        Rst = 1; WrValid = 1; RdReady = 1;
        for (int c = 0; c < 3; c++) begin
            step(); #1;
            n_tests++; if (WrReady !== 1'b0) begin n_fail++; $display("FAIL rst_wrready c%0d: got %b expected 0", c, WrReady); end
            n_tests++; if ({CEAB, WEAB, CEBB, REBB} !== 4'hf) begin n_fail++; $display("FAIL rst_enables c%0d: got %h expected f", c, {CEAB, WEAB, CEBB, REBB}); end
            n_tests++; if (Count !== '0) begin n_fail++; $display("FAIL rst_count c%0d: got %0d expected 0", c, Count); end
            n_tests++; if (RdValid !== 1'b0) begin n_fail++; $display("FAIL rst_rdvalid c%0d: got %b expected 0", c, RdValid); end
        end
        Rst = 0; WrValid = 0; RdReady = 0; #1;
        n_tests++; if (WrReady !== 1'b1) begin n_fail++; $display("FAIL rst_release_wrready: got %b expected 1", WrReady); end
        n_tests++; if (OvfErr !== 1'b0) begin n_fail++; $display("FAIL rst_ovferr: got %b expected 0", OvfErr); end
        step();
    endtask

    task automatic test_single();
        WrValid = 1; WrData = DW'(32'h1234); RdReady = 0; #1;
        n_tests++; if ({CEAB, WEAB} !== 2'b00) begin n_fail++; $display("FAIL single_portA_en: got %b expected 00", {CEAB, WEAB}); end
        n_tests++; if (AddrA !== '0) begin n_fail++; $display("FAIL single_addra: got %0d expected 0", AddrA); end
        n_tests++; if (Din !== DW'(32'h1234)) begin n_fail++; $display("FAIL single_din: got %0h expected 1234", Din); end
        step(); WrValid = 0; #1;
        n_tests++; if ({CEBB, REBB} !== 2'b00) begin n_fail++; $display("FAIL single_portB_en: got %b expected 00", {CEBB, REBB}); end
        n_tests++; if (AddrB !== '0) begin n_fail++; $display("FAIL single_addrb: got %0d expected 0", AddrB); end
        step(); #1;
        n_tests++; if (RdValid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0", RdValid); end
        step(); #1;
        n_tests++; if (RdValid !== 1'b1) begin n_fail++; $display("FAIL single_rdvalid: got %b expected 1", RdValid); end
        n_tests++; if (RdData !== DW'(32'h1234)) begin n_fail++; $display("FAIL single_rddata: got %0h expected 1234", RdData); end
        RdReady = 1; step(); RdReady = 0; #1;
        n_tests++; if (RdValid !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %b expected 0", RdValid); end
    endtask

    task automatic test_fill();
        int acc = 0, cyc = 0, rd = 0, mism = 0;
        WrValid = 1; RdReady = 0;
        while (acc < DEPTH + 2 && cyc < 3000) begin
            WrData = DW'(acc); #1;
            if (WrReady) acc++;
            step(); cyc++;
        end
        #1;
        n_tests++; if (acc !== DEPTH + 2 || cyc !== DEPTH + 2) begin n_fail++; $display("FAIL fill_accepts: got %0d in %0d cycles expected 1026 in 1026", acc, cyc); end
        n_tests++; if (WrReady !== 1'b0) begin n_fail++; $display("FAIL fill_wrready: got %b expected 0", WrReady); end
        n_tests++; if (Count !== 11'd1024) begin n_fail++; $display("FAIL fill_count: got %0d expected 1024", Count); end
        step(); #1;
        n_tests++; if (Count !== 11'd1024 || CEAB !== 1'b1) begin n_fail++; $display("FAIL fill_extra_write: count %0d ceab %b expected 1024 1", Count, CEAB); end
        WrValid = 0; RdReady = 1; cyc = 0;
        while (rd < DEPTH + 2 && cyc < 3000) begin
            #1;
            if (RdValid) begin if (RdData !== DW'(rd)) mism++; rd++; end
            step(); cyc++;
        end
        RdReady = 0; #1;
        n_tests++; if (rd !== DEPTH + 2 || mism !== 0) begin n_fail++; $display("FAIL fill_drain: got %0d reads %0d bad expected 1026 reads 0 bad", rd, mism); end
        n_tests++; if (Count !== '0 || RdValid !== 1'b0 || OvfErr !== 1'b0) begin n_fail++; $display("FAIL fill_empty: count %0d rdvalid %b ovf %b expected 0 0 0", Count, RdValid, OvfErr); end
    endtask

    task automatic test_stream();
        int wr = 0, rd = 0, mism = 0, bub = 0;
        bit started = 0;
        RdReady = 1;
        for (int cyc = 0; cyc < 7000 && rd < 5000; cyc++) begin
            WrValid = wr < 5000; WrData = DW'(wr); #1;
            if (WrValid && WrReady) wr++;
            if (RdValid) begin if (RdData !== DW'(rd)) mism++; rd++; started = 1; end
            else if (started) bub++;
            step();
        end
        WrValid = 0; RdReady = 0;
        n_tests++; if (rd !== 5000 || mism !== 0) begin n_fail++; $display("FAIL stream_data: got %0d reads %0d bad expected 5000 reads 0 bad", rd, mism); end
        n_tests++; if (bub !== 0) begin n_fail++; $display("FAIL stream_bubbles: got %0d expected 0", bub); end
        n_tests++; if (OvfErr !== 1'b0) begin n_fail++; $display("FAIL stream_ovferr: got %b expected 0", OvfErr); end
    endtask

    task automatic test_wrap();
        localparam int N = 3 * DEPTH + 50;
        logic [DW-1:0] q[$];
        int wr = 0, rd = 0, mism = 0, coll = 0, aw = 0, bw = 0;
        for (int cyc = 0; cyc < 20000 && rd < N; cyc++) begin
            WrValid = (wr < N) && ($urandom_range(0, 3) != 0);
            WrData = DW'({$urandom(), $urandom(), $urandom()});
            RdReady = $urandom_range(0, 1) == 1;
            #1;
            if (!CEAB && !CEBB && AddrA == AddrB) coll++;
            if (!CEBB && !REBB && AddrB == AW'(DEPTH - 1)) bw++;
            if (RdValid && RdReady) begin
                if (q.size() == 0) mism++;
                else if (RdData !== q.pop_front()) mism++;
                rd++;
            end
            if (WrValid && WrReady) begin q.push_back(WrData); wr++; if (AddrA == AW'(DEPTH - 1)) aw++; end
            step();
        end
        WrValid = 0; RdReady = 0;
        n_tests++; if (rd !== N || mism !== 0) begin n_fail++; $display("FAIL wrap_data: got %0d reads %0d bad expected %0d reads 0 bad", rd, mism, N); end
        n_tests++; if (coll !== 0) begin n_fail++; $display("FAIL wrap_collision: got %0d expected 0", coll); end
        n_tests++; if (aw < 3 || bw < 3) begin n_fail++; $display("FAIL wrap_passes: got %0d/%0d expected >=3/>=3", aw, bw); end
        n_tests++; if (OvfErr !== 1'b0) begin n_fail++; $display("FAIL wrap_ovferr: got %b expected 0", OvfErr); end
    endtask

    task automatic test_backpressure();
        localparam int N = 2000;
        logic [DW-1:0] q[$];
        int wr = 0, rd = 0, mism = 0, viol = 0, d;
        bit tog = 1;
        for (int cyc = 0; cyc < 10000 && rd < N; cyc++) begin
            WrValid = wr < N; WrData = DW'(wr + 7000); RdReady = tog; tog = !tog;
            #1;
            d = q.size() - int'(Count);
            if (d < 0 || d > 2) viol++;
            if (RdValid && RdReady) begin
                if (q.size() == 0) mism++;
                else if (RdData !== q.pop_front()) mism++;
                rd++;
            end
            if (WrValid && WrReady) begin q.push_back(WrData); wr++; end
            step();
        end
        WrValid = 0; RdReady = 0; #1;
        n_tests++; if (rd !== N || mism !== 0) begin n_fail++; $display("FAIL bp_data: got %0d reads %0d bad expected %0d reads 0 bad", rd, mism, N); end
        n_tests++; if (viol !== 0) begin n_fail++; $display("FAIL bp_buffer_occupancy: got %0d violations expected 0", viol); end
        n_tests++; if (OvfErr !== 1'b0 || RdValid !== 1'b0) begin n_fail++; $display("FAIL bp_final: ovf %b rdvalid %b expected 0 0", OvfErr, RdValid); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_stream();
        test_wrap();
        test_backpressure();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
